// File: rtl/win_extrema_pkg.sv
// Shared constants and helpers for the sliding-window extremum tracker.
package win_extrema_pkg;

    localparam int W_DEF = 10;
    localparam int D_DEF = 4;

    localparam int CMP_UNSIGNED = 0;
    localparam int CMP_SIGNED   = 1;

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/win_extrema_if.sv
// Sample stream in, window statistics out.
interface win_extrema_if
    import win_extrema_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int D = D_DEF
);
    localparam int CW = cnt_w(D);

    logic          en;
    logic          clr;
    logic [W-1:0]  x;
    logic [W-1:0]  y_max;
    logic [W-1:0]  y_min;
    logic [CW-1:0] cnt;
    logic          full;
    logic          valid;

    modport master (
        output en, clr, x,
        input  y_max, y_min, cnt, full, valid
    );

    modport slave (
        input  en, clr, x,
        output y_max, y_min, cnt, full, valid
    );

endinterface

// File: rtl/win_extrema_ext_tree.sv
// Balanced masked max/min reduction over D buffer entries.
module ext_tree
    import win_extrema_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int D      = D_DEF,
    parameter int SIGNED = CMP_UNSIGNED
) (
    input  logic [D*W-1:0] data,
    input  logic [D-1:0]   mask,
    output logic [W-1:0]   y_max,
    output logic [W-1:0]   y_min
);
    localparam int P = 1 << $clog2(D);
    localparam int N = 2 * P - 1;

    // Masked-off leaves get the identity value so they never win.
    localparam logic [W-1:0] LO =
        (SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};
    localparam logic [W-1:0] HI =
        (SIGNED != 0) ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};

    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic [W-1:0] mx [N];
    logic [W-1:0] mn [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mx[i] = LO;
            mn[i] = HI;
        end
        for (int i = 0; i < D; i++) begin
            if (mask[i]) begin
                mx[P-1+i] = data[i*W +: W];
                mn[P-1+i] = data[i*W +: W];
            end
        end
        for (int n = P - 2; n >= 0; n--) begin
            mx[n] = gt(mx[2*n+1], mx[2*n+2]) ? mx[2*n+1] : mx[2*n+2];
            mn[n] = gt(mn[2*n+1], mn[2*n+2]) ? mn[2*n+2] : mn[2*n+1];
        end
        y_max = mx[0];
        y_min = mn[0];
    end

endmodule

// File: rtl/win_extrema.sv
// Sliding-window max/min over the last D accepted samples.
module win_extrema
    import win_extrema_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int D      = D_DEF,
    parameter int SIGNED = CMP_UNSIGNED
) (
    input logic           clk,
    input logic           rst,
    win_extrema_if.slave  bus
);
    localparam int CW = cnt_w(D);
    localparam int PW = $clog2(D);

    logic [W-1:0]   mem_q [D];
    logic [PW-1:0]  wp_q;
    logic [CW-1:0]  cnt_q;
    logic [D*W-1:0] flat;
    logic [D-1:0]   mask;
    logic [W-1:0]   t_max;
    logic [W-1:0]   t_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < D; i++)
                mem_q[i] <= '0;
        end else if (bus.en) begin
            if (bus.clr) begin
                // Clear first, then the sample lands in slot 0.
                mem_q[0] <= bus.x;
                wp_q     <= PW'(1);
                cnt_q    <= CW'(1);
            end else begin
                mem_q[wp_q] <= bus.x;
                wp_q  <= (wp_q == PW'(D - 1)) ? '0 : wp_q + 1'b1;
                if (cnt_q != CW'(D))
                    cnt_q <= cnt_q + 1'b1;
            end
        end else if (bus.clr) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end
    end

    // Entry i is valid when its age behind wp is below cnt.
    always_comb begin
        int age;
        flat = '0;
        mask = '0;
        for (int i = 0; i < D; i++) begin
            flat[i*W +: W] = mem_q[i];
            age = int'(wp_q) - 1 - i;
            if (age < 0)
                age = age + D;
            mask[i] = age < int'(cnt_q);
        end
    end

    ext_tree #(
        .W      (W),
        .D      (D),
        .SIGNED (SIGNED)
    ) u_tree (
        .data  (flat),
        .mask  (mask),
        .y_max (t_max),
        .y_min (t_min)
    );

    assign bus.valid = (cnt_q != '0);
    assign bus.full  = (cnt_q == CW'(D));
    assign bus.cnt   = cnt_q;
    assign bus.y_max = bus.valid ? t_max : '0;
    assign bus.y_min = bus.valid ? t_min : '0;

endmodule

// File: tb/tb_win_extrema.sv
// Self-checking bench: three window configurations against queue models.
module tb_win_extrema;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] x   = '0;

    int errors = 0;
    int checks = 0;

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];

    always #5 clk = ~clk;

    win_extrema_if #(.W(10), .D(4)) if0 ();
    win_extrema_if #(.W(10), .D(4)) if1 ();
    win_extrema_if #(.W(10), .D(5)) if2 ();

    assign if0.en = en;
    assign if0.clr = clr;
    assign if0.x = x;
    assign if1.en = en;
    assign if1.clr = clr;
    assign if1.x = x;
    assign if2.en = en;
    assign if2.clr = clr;
    assign if2.x = x;

    win_extrema #(.W(10), .D(4), .SIGNED(0)) u0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    win_extrema #(.W(10), .D(4), .SIGNED(1)) u1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    win_extrema #(.W(10), .D(5), .SIGNED(0)) u2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    // Extremum of a window held as a plain list of samples.
    function automatic logic [9:0] ref_ext(
        input logic [9:0] q [$],
        input bit         sgn,
        input bit         want_max
    );
        logic [9:0] r;
        bit         better;
        if (q.size() == 0)
            return '0;
        r = q[0];
        foreach (q[i]) begin
            if (sgn)
                better = want_max ? ($signed(q[i]) > $signed(r))
                                  : ($signed(q[i]) < $signed(r));
            else
                better = want_max ? (q[i] > r) : (q[i] < r);
            if (better)
                r = q[i];
        end
        return r;
    endfunction

    function automatic void push(inout logic [9:0] q [$], input logic [9:0] v, input int d);
        q.push_back(v);
        if (q.size() > d)
            void'(q.pop_front());
    endfunction

    task automatic step(input logic e, input logic c, input logic [9:0] v);
        en  = e;
        clr = c;
        x   = v;
        @(posedge clk);
        #1;
        en  = 1'b0;
        clr = 1'b0;
        if (c) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
        if (e) begin
            push(q0, v, 4);
            push(q1, v, 4);
            push(q2, v, 5);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (if0.y_max !== 10'd0 || if0.y_min !== 10'd0) begin
            errors++;
            $display("FAIL reset_ext: got max=%0d min=%0d want 0/0", if0.y_max, if0.y_min);
        end
        checks++;
        if (if0.cnt !== 3'd0 || if0.valid !== 1'b0 || if0.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d valid=%b full=%b want 0/0/0",
                     if0.cnt, if0.valid, if0.full);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 10'd600);
        step(1'b1, 1'b0, 10'd700);
        // Reset lands between edges; outputs must drop without a clock.
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (if0.cnt !== 3'd0 || if0.y_max !== 10'd0 || if0.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got cnt=%0d max=%0d valid=%b want 0/0/0",
                     if0.cnt, if0.y_max, if0.valid);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 10'd11);
        checks++;
        if (if0.cnt !== 3'd1 || if0.y_max !== 10'd11 || if0.y_min !== 10'd11) begin
            errors++;
            $display("FAIL reset_first: got cnt=%0d max=%0d min=%0d want 1/11/11",
                     if0.cnt, if0.y_max, if0.y_min);
        end
        step(1'b0, 1'b1, 10'd0);
    endtask

    task automatic test_fill();
        step(1'b1, 1'b0, 10'd5);
        checks++;
        if (if0.y_max !== 10'd5 || if0.y_min !== 10'd5 || if0.cnt !== 3'd1) begin
            errors++;
            $display("FAIL fill_first: got max=%0d min=%0d cnt=%0d want 5/5/1",
                     if0.y_max, if0.y_min, if0.cnt);
        end
        step(1'b1, 1'b0, 10'd900);
        step(1'b1, 1'b0, 10'd3);
        step(1'b1, 1'b0, 10'd7);
        checks++;
        if (if0.y_max !== 10'd900 || if0.y_min !== 10'd3) begin
            errors++;
            $display("FAIL fill_ext: got max=%0d min=%0d want 900/3", if0.y_max, if0.y_min);
        end
        checks++;
        if (if0.cnt !== 3'd4 || if0.full !== 1'b1 || if0.valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_flags: got cnt=%0d full=%b valid=%b want 4/1/1",
                     if0.cnt, if0.full, if0.valid);
        end
    endtask

    task automatic test_eviction();
        step(1'b1, 1'b0, 10'd8);
        checks++;
        if (if0.y_max !== 10'd900 || if0.cnt !== 3'd4) begin
            errors++;
            $display("FAIL evict_8: got max=%0d cnt=%0d want 900/4", if0.y_max, if0.cnt);
        end
        step(1'b1, 1'b0, 10'd9);
        checks++;
        if (if0.y_max !== 10'd9 || if0.y_min !== 10'd3) begin
            errors++;
            $display("FAIL evict_9: got max=%0d min=%0d want 9/3", if0.y_max, if0.y_min);
        end
        step(1'b1, 1'b0, 10'd1);
        checks++;
        if (if0.y_min !== 10'd1 || if0.y_max !== 10'd9) begin
            errors++;
            $display("FAIL evict_1: got max=%0d min=%0d want 9/1", if0.y_max, if0.y_min);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 1'b1, 10'd42);
        checks++;
        if (if0.cnt !== 3'd1 || if0.y_max !== 10'd42 || if0.y_min !== 10'd42) begin
            errors++;
            $display("FAIL clear_accept: got cnt=%0d max=%0d min=%0d want 1/42/42",
                     if0.cnt, if0.y_max, if0.y_min);
        end
        step(1'b0, 1'b1, 10'd77);
        checks++;
        if (if0.cnt !== 3'd0 || if0.y_max !== 10'd0 || if0.y_min !== 10'd0
            || if0.valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_only: got cnt=%0d max=%0d min=%0d valid=%b want 0/0/0/0",
                     if0.cnt, if0.y_max, if0.y_min, if0.valid);
        end
    endtask

    task automatic test_signed();
        step(1'b1, 1'b0, 10'h3FF);
        step(1'b1, 1'b0, 10'h001);
        step(1'b1, 1'b0, 10'h200);
        checks++;
        if (if1.y_max !== 10'h001 || if1.y_min !== 10'h200) begin
            errors++;
            $display("FAIL signed_ext: got max=%h min=%h want 001/200", if1.y_max, if1.y_min);
        end
        checks++;
        if (if0.y_max !== 10'h3FF || if0.y_min !== 10'h001) begin
            errors++;
            $display("FAIL unsigned_ext: got max=%h min=%h want 3ff/001", if0.y_max, if0.y_min);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 10'($urandom));
            checks++;
            if (if0.y_max !== ref_ext(q0, 1'b0, 1'b1)
                || if0.y_min !== ref_ext(q0, 1'b0, 1'b0)
                || if0.cnt !== 3'(q0.size())) begin
                errors++;
                $display("FAIL hold_%0d: got max=%h min=%h cnt=%0d want %h/%h/%0d", i,
                         if0.y_max, if0.y_min, if0.cnt,
                         ref_ext(q0, 1'b0, 1'b1), ref_ext(q0, 1'b0, 1'b0), q0.size());
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] v;
        for (int i = 0; i < 100; i++) begin
            v = 10'($urandom % 1000);
            step(1'b1, 1'b0, v);
            checks++;
            if (if2.y_max !== ref_ext(q2, 1'b0, 1'b1)
                || if2.y_min !== ref_ext(q2, 1'b0, 1'b0)
                || if2.cnt !== 3'(q2.size())
                || if2.full !== (q2.size() == 5)) begin
                errors++;
                $display("FAIL rand_d5_%0d: got max=%0d min=%0d cnt=%0d want %0d/%0d/%0d", i,
                         if2.y_max, if2.y_min, if2.cnt,
                         ref_ext(q2, 1'b0, 1'b1), ref_ext(q2, 1'b0, 1'b0), q2.size());
            end
            checks++;
            if (if1.y_max !== ref_ext(q1, 1'b1, 1'b1)
                || if1.y_min !== ref_ext(q1, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL rand_sgn_%0d: got max=%h min=%h want %h/%h", i,
                         if1.y_max, if1.y_min,
                         ref_ext(q1, 1'b1, 1'b1), ref_ext(q1, 1'b1, 1'b0));
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_fill();
        test_eviction();
        test_clear();
        test_signed();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
